// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel types and widths for the 2x2 decimator
// IMG_DECIM_ROUND_EN selects round-half-up in div4; truncation otherwise.
package img_pkg;
  localparam int PIX_W      = 24;
  localparam int CH_W       = 8;
  localparam int NUM_CH     = 3;
  localparam int R_OFS      = 0;
  localparam int G_OFS      = 8;
  localparam int B_OFS      = 16;
  localparam int PAIR_W     = 9;
  localparam int BLK_W      = 10;
  localparam int PAIR_SUM_W = NUM_CH * PAIR_W;
  localparam int BLK_SUM_W  = NUM_CH * BLK_W;

  typedef struct packed {
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
  } pixel_t;

`ifdef IMG_DECIM_ROUND_EN
  localparam logic [BLK_W-1:0] DIV_RND = BLK_W'(2);
`else
  localparam logic [BLK_W-1:0] DIV_RND = BLK_W'(0);
`endif

  function automatic logic [PAIR_W-1:0] add_pair(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Max block sum is 1020, so adding the rounding constant cannot overflow 10 bits.
  function automatic logic [CH_W-1:0] div4(input logic [BLK_W-1:0] s);
    return CH_W'((s + DIV_RND) >> 2);
  endfunction
endpackage

// File: rtl/img_decim_linebuf.sv
// rtl/img_decim_linebuf.sv - simple dual-port line buffer of pair sums
// Storage is never reset; read data is registered and held between reads.
module img_decim_linebuf
  import img_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = PAIR_SUM_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/img_decim2x2.sv
// rtl/img_decim2x2.sv - 2x2 box-filter downscaler for 24-bit RGB raster streams
// Build option IMG_DECIM_ROUND_EN (see img_pkg) switches averaging to round-half-up.
module img_decim2x2
  import img_pkg::*;
#(
  parameter int SIZE_X = 64,
  parameter int SIZE_Y = 64,
  parameter int LEN_X  = $clog2(SIZE_X),
  parameter int LEN_Y  = $clog2(SIZE_Y)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             de_in,
  input  logic             vsync_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             de_out,
  output logic             vsync_out
);
  localparam int AW = LEN_X - 1;
  localparam logic [LEN_X-1:0] X_LAST = LEN_X'(SIZE_X - 1);
  localparam logic [LEN_Y-1:0] Y_LAST = LEN_Y'(SIZE_Y - 1);

  logic [LEN_X-1:0]      x_q, x_d;
  logic [LEN_Y-1:0]      y_q, y_d;
  pixel_t                latch_q, latch_d, pix_in;
  logic                  s1_valid_q, s1_valid_d;
  logic [PAIR_SUM_W-1:0] s1_pair_q, s1_pair_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [BLK_SUM_W-1:0]  s2_blk_q, s2_blk_d;
  logic [PIX_W-1:0]      pix_out_q, pix_out_d;
  logic                  de_out_q, de_out_d;
  logic [1:0]            vs_q, vs_d;
  logic                  beat;
  logic [PAIR_SUM_W-1:0] pair_now, lb_rdata;

  assign pix_in   = pixel_in;
  assign beat     = de_in & ~vsync_in;
  assign pair_now = {add_pair(latch_q.b, pix_in.b),
                     add_pair(latch_q.g, pix_in.g),
                     add_pair(latch_q.r, pix_in.r)};

  // Even rows store pair sums; odd rows fetch them one beat before they are consumed.
  img_decim_linebuf #(
    .DEPTH(SIZE_X / 2),
    .AW   (AW),
    .DW   (PAIR_SUM_W)
  ) u_linebuf (
    .clk  (clk),
    .we   (beat & x_q[0] & ~y_q[0]),
    .waddr(x_q[LEN_X-1:1]),
    .wdata(pair_now),
    .re   (beat & ~x_q[0] & y_q[0]),
    .raddr(x_q[LEN_X-1:1]),
    .rdata(lb_rdata)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    latch_d = latch_q;
    if (vsync_in) begin
      x_d     = '0;
      y_d     = '0;
      latch_d = '0;
    end else if (de_in) begin
      if (!x_q[0]) latch_d = pix_in;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + LEN_Y'(1);
      end else begin
        x_d = x_q + LEN_X'(1);
      end
    end
  end

  always_comb begin
    s1_valid_d = beat & x_q[0] & y_q[0];
    s1_pair_d  = s1_valid_d ? pair_now : s1_pair_q;
    s2_valid_d = s1_valid_q;
    s2_blk_d   = s2_blk_q;
    de_out_d   = s2_valid_q;
    pix_out_d  = pix_out_q;
    vs_d       = {vs_q[0], vsync_in};
    // Read data stays stable until the next even-column read, which lands after this add.
    if (s1_valid_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s2_blk_d[c*BLK_W +: BLK_W] = {1'b0, s1_pair_q[c*PAIR_W +: PAIR_W]}
                                   + {1'b0, lb_rdata[c*PAIR_W +: PAIR_W]};
      end
    end
    if (s2_valid_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        pix_out_d[c*CH_W +: CH_W] = div4(s2_blk_q[c*BLK_W +: BLK_W]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      latch_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_pair_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_blk_q   <= '0;
      pix_out_q  <= '0;
      de_out_q   <= 1'b0;
      vs_q       <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      latch_q    <= latch_d;
      s1_valid_q <= s1_valid_d;
      s1_pair_q  <= s1_pair_d;
      s2_valid_q <= s2_valid_d;
      s2_blk_q   <= s2_blk_d;
      pix_out_q  <= pix_out_d;
      de_out_q   <= de_out_d;
      vs_q       <= vs_d;
    end
  end

  assign pixel_out = pix_out_q;
  assign de_out    = de_out_q;
  assign vsync_out = vs_q[1];
endmodule
